logic_sweep_unit: RTL and testbench

LOGIC_SWEEP_UNIT -- requirements
Module: logic_sweep_unit

---
 rtl/logic_sweep_pkg.sv | 19 +
 rtl/logic_op_core.sv | 48 ++++
 rtl/logic_sweep_unit.sv | 114 +++++++++++
 tb/tb_logic_sweep_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/logic_sweep_pkg.sv
// Shared encodings for the logic sweep unit: op select codes and sweep FSM states.
package logic_sweep_pkg;

  localparam logic [2:0] OP_IMPLY  = 3'd0;
  localparam logic [2:0] OP_NAND   = 3'd1;
  localparam logic [2:0] OP_AND    = 3'd2;
  localparam logic [2:0] OP_OR     = 3'd3;
  localparam logic [2:0] OP_NOR    = 3'd4;
  localparam logic [2:0] OP_XOR    = 3'd5;
  localparam logic [2:0] OP_XNOR   = 3'd6;
  localparam logic [2:0] OP_NIMPLY = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise evaluator; every op is built from 2-input NAND terms only,
// then one of the eight results is picked by op.
module logic_op_core
  import logic_sweep_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s
);

  function automatic logic [WIDTH-1:0] nand_g(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return ~(x & y);
  endfunction

  logic [WIDTH-1:0] n_ab, n_a, n_b;
  logic [WIDTH-1:0] r_imply, r_and, r_or, r_nor, r_xor, r_xnor, r_nimply;

  assign n_ab     = nand_g(a, b);
  assign n_a      = nand_g(a, a);
  assign n_b      = nand_g(b, b);
  assign r_imply  = nand_g(a, n_b);                          // ~a | b
  assign r_and    = nand_g(n_ab, n_ab);
  assign r_or     = nand_g(n_a, n_b);
  assign r_nor    = nand_g(r_or, r_or);
  assign r_xor    = nand_g(nand_g(a, n_ab), nand_g(b, n_ab));
  assign r_xnor   = nand_g(r_xor, r_xor);
  assign r_nimply = nand_g(r_imply, r_imply);                // a & ~b

  // Select the requested function result
  always_comb begin
    s = n_ab;
    case (op)
      OP_IMPLY:  s = r_imply;
      OP_NAND:   s = n_ab;
      OP_AND:    s = r_and;
      OP_OR:     s = r_or;
      OP_NOR:    s = r_nor;
      OP_XOR:    s = r_xor;
      OP_XNOR:   s = r_xnor;
      OP_NIMPLY: s = r_nimply;
      default:   s = n_ab;
    endcase
  end

endmodule

// File: rtl/logic_sweep_unit.sv
// Bitwise logic unit with a registered valid/ready result path and an optional
// exhaustive operand sweep that counts all-ones results.
// Sweep hardware is built only when LOGIC_SWEEP_EN is defined; otherwise the
// sweep ports stay present but inert.
module logic_sweep_unit
  import logic_sweep_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2*WIDTH+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [CNT_W-1:0] ones_count
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [2:0]       core_op;
  logic [WIDTH-1:0] core_a, core_b, core_s;
  logic             accept;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op (core_op),
    .a  (core_a),
    .b  (core_b),
    .s  (core_s)
  );

  assign accept = in_valid & in_ready;

`ifdef LOGIC_SWEEP_EN
  state_t                 state, state_nxt;
  logic [2*WIDTH-1:0]     idx;
  logic [2:0]             sw_op;

  // While running, the shared core evaluates the current sweep pair instead of the request
  assign core_op = (state == RUN) ? sw_op : op;
  assign core_a  = (state == RUN) ? idx[2*WIDTH-1:WIDTH] : a;
  assign core_b  = (state == RUN) ? idx[WIDTH-1:0] : b;

  assign in_ready   = (state == IDLE) & ~sweep_start & (~out_valid | out_ready);
  assign sweep_busy = (state != IDLE);
  assign sweep_done = (state == DONE);

  // Sweep state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Sweep next-state: start only from IDLE, leave RUN after the last pair, DONE lasts one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sweep_start) state_nxt = RUN;
      RUN:     if (idx == '1)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pair index, latched op and all-ones counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      sw_op      <= OP_IMPLY;
      ones_count <= '0;
    end else if (state == IDLE && sweep_start) begin
      idx        <= '0;
      sw_op      <= op;
      ones_count <= '0;
    end else if (state == RUN) begin
      idx <= idx + 1'b1;
      if (core_s == ALL_ONES) ones_count <= ones_count + CNT_W'(1);
    end
  end
`else
  logic sweep_unused;

  assign sweep_unused = sweep_start;
  assign core_op      = op;
  assign core_a       = a;
  assign core_b       = b;
  assign in_ready     = ~out_valid | out_ready;
  assign sweep_busy   = 1'b0;
  assign sweep_done   = 1'b0;
  assign ones_count   = '0;
`endif

  // Output register: load on accept (even while the old result is consumed), hold under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      s         <= core_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_sweep_unit.sv
// Directed bench: a WIDTH=4 instance covers the request path, a WIDTH=2 instance
// covers the sweep (or its absence when LOGIC_SWEEP_EN is not defined).
module tb_logic_sweep_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // WIDTH=4 instance
  logic       iv4 = 0, or4 = 0, ss4 = 0;
  logic [2:0] op4 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic       ir4, ov4, sb4, sd4;
  logic [3:0] s4;
  logic [8:0] oc4;

  logic_sweep_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .op(op4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .s(s4), .sweep_start(ss4), .sweep_busy(sb4),
    .sweep_done(sd4), .ones_count(oc4)
  );

  // WIDTH=2 instance
  logic       iv2 = 0, or2 = 0, ss2 = 0;
  logic [2:0] op2 = 0;
  logic [1:0] a2 = 0, b2 = 0;
  logic       ir2, ov2, sb2, sd2;
  logic [1:0] s2;
  logic [4:0] oc2;

  logic_sweep_unit #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .op(op2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(or2), .s(s2), .sweep_start(ss2), .sweep_busy(sb2),
    .sweep_done(sd2), .ones_count(oc2)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    #1;
    n_tests++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL reset_ov4 got %b exp 0", ov4); end
    n_tests++; if (s4 !== 4'h0) begin n_fail++; $display("FAIL reset_s4 got %h exp 0", s4); end
    n_tests++; if (ir4 !== 1'b1) begin n_fail++; $display("FAIL reset_ir4 got %b exp 1", ir4); end
    n_tests++; if ({sb2, sd2} !== 2'b00) begin n_fail++; $display("FAIL reset_sweep got %b exp 00", {sb2, sd2}); end
    n_tests++; if (oc2 !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", oc2); end
    @(negedge clk); rst = 1'b0;
  endtask

  // op=0, a=6, b=3 -> ~0110|0011 = 1011
  task automatic test_imply();
    @(negedge clk); iv4 = 1; op4 = 3'd0; a4 = 4'h6; b4 = 4'h3; or4 = 1;
    tick();
    n_tests++; if (ov4 !== 1'b1) begin n_fail++; $display("FAIL imply_valid got %b exp 1", ov4); end
    n_tests++; if (s4 !== 4'hB) begin n_fail++; $display("FAIL imply_s got %h exp b", s4); end
    iv4 = 0;
    tick();
    n_tests++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL imply_drain got %b exp 0", ov4); end
  endtask

  // NAND F,A = 5 held under backpressure; AND F,3 = 3 accepted when out_ready rises
  task automatic test_backpressure();
    @(negedge clk); iv4 = 1; op4 = 3'd1; a4 = 4'hF; b4 = 4'hA; or4 = 0;
    tick();
    op4 = 3'd2; a4 = 4'hF; b4 = 4'h3;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (ir4 !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp 0", i, ir4); end
      n_tests++; if ({ov4, s4} !== 5'h15) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b s=%h exp v=1 s=5", i, ov4, s4); end
      tick();
    end
    or4 = 1; #1;
    n_tests++; if (ir4 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise got %b exp 1", ir4); end
    tick();
    n_tests++; if ({ov4, s4} !== 5'h13) begin n_fail++; $display("FAIL bp_next got v=%b s=%h exp v=1 s=3", ov4, s4); end
    iv4 = 0;
    tick();
  endtask

  // All eight ops on a=C, b=A streamed back to back with consume+accept each edge
  task automatic test_back_to_back();
    logic [3:0] exp_tab [8];
    exp_tab = '{4'hB, 4'h7, 4'h8, 4'hE, 4'h1, 4'h6, 4'h9, 4'h4};
    or4 = 1; a4 = 4'hC; b4 = 4'hA;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); iv4 = 1; op4 = 3'(i);
      tick();
      n_tests++; if ({ov4, s4} !== {1'b1, exp_tab[i]}) begin
        n_fail++; $display("FAIL b2b_op%0d got v=%b s=%h exp v=1 s=%h", i, ov4, s4, exp_tab[i]);
      end
    end
    @(negedge clk); iv4 = 0;
    tick();
  endtask

`ifdef LOGIC_SWEEP_EN
  // Runs one sweep on dut2 and checks duration, single done pulse and the count
  task automatic run_sweep(input logic [2:0] sop, input int exp_cnt, input string nm);
    int busy = 0, done = 0, k = 0;
    @(negedge clk); ss2 = 1; op2 = sop; iv2 = 1; #1;
    n_tests++; if (ir2 !== 1'b0) begin n_fail++; $display("FAIL %s_start_ready got %b exp 0", nm, ir2); end
    forever begin
      tick();
      if (k == 0) begin ss2 = 0; iv2 = 0; op2 = 3'd1; end
      k++;
      if (sb2) busy++;
      if (sd2) begin
        done++;
        n_tests++; if (sb2 !== 1'b1) begin n_fail++; $display("FAIL %s_busy_in_done got %b exp 1", nm, sb2); end
      end
      if (!sb2 || k > 100) break;
    end
    n_tests++; if (busy != 17) begin n_fail++; $display("FAIL %s_busy_cycles got %0d exp 17", nm, busy); end
    n_tests++; if (done != 1) begin n_fail++; $display("FAIL %s_done_pulses got %0d exp 1", nm, done); end
    n_tests++; if (oc2 !== 5'(exp_cnt)) begin n_fail++; $display("FAIL %s_count got %0d exp %0d", nm, oc2, exp_cnt); end
  endtask

  task automatic test_sweep();
    // Park a result (OR 1,2 = 3) with out_ready low; the sweep must not disturb it
    @(negedge clk); iv2 = 1; op2 = 3'd3; a2 = 2'd1; b2 = 2'd2; or2 = 0;
    tick();
    iv2 = 0;
    run_sweep(3'd0, 9, "sweep_imply");
    n_tests++; if ({ov2, s2} !== 3'b111) begin n_fail++; $display("FAIL sweep_pending got v=%b s=%h exp v=1 s=3", ov2, s2); end
    tick(); tick();
    n_tests++; if (oc2 !== 5'd9) begin n_fail++; $display("FAIL sweep_count_hold got %0d exp 9", oc2); end
    @(negedge clk); or2 = 1;
    tick();
    run_sweep(3'd2, 1, "sweep_and");
    run_sweep(3'd5, 4, "sweep_xor");
  endtask

  task automatic test_abort();
    int done = 0;
    @(negedge clk); ss2 = 1; op2 = 3'd0;
    tick();
    ss2 = 0;
    for (int i = 0; i < 5; i++) begin
      if (sd2) done++;
      tick();
    end
    rst = 1; #1;
    n_tests++; if ({sb2, sd2, ov2, s2} !== 5'b0) begin n_fail++; $display("FAIL abort_outputs got %b exp 00000", {sb2, sd2, ov2, s2}); end
    n_tests++; if (oc2 !== 5'd0) begin n_fail++; $display("FAIL abort_count got %0d exp 0", oc2); end
    tick();
    if (sd2) done++;
    @(negedge clk); rst = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sd2) done++;
    end
    n_tests++; if (done != 0) begin n_fail++; $display("FAIL abort_no_done got %0d exp 0", done); end
    run_sweep(3'd0, 9, "resweep");
  endtask
`else
  // Sweep disabled: start is ignored and the simultaneous request goes through (XOR 1,3 = 2)
  task automatic test_sweep_disabled();
    @(negedge clk); ss2 = 1; iv2 = 1; op2 = 3'd5; a2 = 2'd1; b2 = 2'd3; or2 = 1; #1;
    n_tests++; if (ir2 !== 1'b1) begin n_fail++; $display("FAIL dis_ready got %b exp 1", ir2); end
    tick();
    ss2 = 0; iv2 = 0;
    n_tests++; if ({ov2, s2} !== 3'b110) begin n_fail++; $display("FAIL dis_accept got v=%b s=%h exp v=1 s=2", ov2, s2); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if ({sb2, sd2, oc2} !== 7'd0) begin n_fail++; $display("FAIL dis_idle[%0d] got %b exp 0", i, {sb2, sd2, oc2}); end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_imply();
    test_backpressure();
    test_back_to_back();
`ifdef LOGIC_SWEEP_EN
    test_sweep();
    test_abort();
`else
    test_sweep_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
